// File: rtl/door_security_mu.sv
`default_nettype none
// ============================================================================
// Module      : door_security_mu
// Description : Multi-user door access controller. It grants timed access on
//               a password match and forces a timed lockout with an alarm
//               after repeated failed attempts.
//               Optional macro DOOR_ALARM_LATCH_EN makes the alarm sticky
//               until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module door_security_mu #(
    parameter int PW_WIDTH       = 12,
    parameter int NUM_USERS      = 2,
    parameter int MAX_TRIES      = 3,
    parameter int ACCESS_CYCLES  = 4,
    parameter int LOCKOUT_CYCLES = 16,
    localparam int UID_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1,
    localparam int CNT_W = $clog2(MAX_TRIES + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_USERS*PW_WIDTH-1:0] set_password,
    input  logic [PW_WIDTH-1:0]           passin,
    input  logic                          enter,
    output logic                          access,
    output logic [UID_W-1:0]              user_id,
    output logic [CNT_W-1:0]              count,
    output logic                          alram,
    output logic                          locked
);

    localparam int c_tmr_max = (ACCESS_CYCLES > LOCKOUT_CYCLES) ? ACCESS_CYCLES : LOCKOUT_CYCLES;
    localparam int c_tmr_w   = (c_tmr_max > 1) ? $clog2(c_tmr_max) : 1;

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_grant   = 2'd1;
    localparam logic [1:0] c_lockout = 2'd2;

    localparam logic [CNT_W-1:0]   c_max_tries = CNT_W'(MAX_TRIES);
    localparam logic [c_tmr_w-1:0] c_acc_load  = c_tmr_w'(ACCESS_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_lock_load = c_tmr_w'(LOCKOUT_CYCLES - 1);

    logic [1:0]         r_state;
    logic [c_tmr_w-1:0] r_timer;
    logic               w_match;
    logic [UID_W-1:0]   w_match_id;
    logic [CNT_W-1:0]   w_cnt_inc;

    // Scan from the top slot down so the lowest matching index is the last write.
    // An all-zero slot is treated as disabled.
    always_comb begin
        w_match    = 1'b0;
        w_match_id = '0;
        for (int i = NUM_USERS - 1; i >= 0; i--) begin
            if ((set_password[i*PW_WIDTH +: PW_WIDTH] == passin) &&
                (set_password[i*PW_WIDTH +: PW_WIDTH] != '0)) begin
                w_match    = 1'b1;
                w_match_id = UID_W'(i);
            end
        end
    end

    // Only evaluated in IDLE, where count is always below MAX_TRIES, so no wrap.
    assign w_cnt_inc = count + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
            r_timer <= '0;
            access  <= 1'b0;
            user_id <= '0;
            count   <= '0;
            alram   <= 1'b0;
            locked  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (enter) begin
                        if (w_match) begin
                            r_state <= c_grant;
                            r_timer <= c_acc_load;
                            access  <= 1'b1;
                            user_id <= w_match_id;
                            count   <= '0;
                        end else if (w_cnt_inc >= c_max_tries) begin
                            r_state <= c_lockout;
                            r_timer <= c_lock_load;
                            count   <= c_max_tries;
                            alram   <= 1'b1;
                            locked  <= 1'b1;
                        end else begin
                            count   <= w_cnt_inc;
                        end
                    end
                end
                c_grant: begin
                    if (r_timer == '0) begin
                        r_state <= c_idle;
                        access  <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                c_lockout: begin
                    if (r_timer == '0) begin
                        r_state <= c_idle;
                        locked  <= 1'b0;
                        count   <= '0;
`ifdef DOOR_ALARM_LATCH_EN
                        // Alarm stays latched; only reset clears it.
`else
                        alram   <= 1'b0;
`endif
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_door_security_mu.sv
`default_nettype none
// ============================================================================
// Module      : tb_door_security_mu
// Description : Directed self-checking bench for door_security_mu (defaults).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_door_security_mu;

    logic        clk;
    logic        reset;
    logic [23:0] set_password;
    logic [11:0] passin;
    logic        enter;
    logic        access;
    logic [0:0]  user_id;
    logic [1:0]  count;
    logic        alram;
    logic        locked;

    int n_cmp;
    int n_err;

`ifdef DOOR_ALARM_LATCH_EN
    localparam logic c_alarm_after = 1'b1;
`else
    localparam logic c_alarm_after = 1'b0;
`endif

    door_security_mu dut (
        .clk          (clk),
        .reset        (reset),
        .set_password (set_password),
        .passin       (passin),
        .enter        (enter),
        .access       (access),
        .user_id      (user_id),
        .count        (count),
        .alram        (alram),
        .locked       (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One attempt: drive on the falling edge, sampled on the next rising edge,
    // returns 1 ns after that edge with enter dropped.
    task automatic attempt(input logic [11:0] pw);
        @(negedge clk);
        passin = pw;
        enter  = 1'b1;
        @(posedge clk);
        #1;
        enter  = 1'b0;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        set_password = {12'h5C3, 12'h0A8};
        passin       = 12'h0A8;
        enter        = 1'b1;
        reset        = 1'b1;

        // Reset dominates even with a valid attempt pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_access", 32'(access), 32'd0);
        check("rst_user",   32'(user_id), 32'd0);
        check("rst_count",  32'(count), 32'd0);
        check("rst_alram",  32'(alram), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);

        reset = 1'b0;
        @(posedge clk);
        #1;
        enter = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("grant0_access", 32'(access), 32'd1);
            check("grant0_user",   32'(user_id), 32'd0);
        end
        @(negedge clk);
        check("grant0_end", 32'(access), 32'd0);

        // Two failures then user 1
        attempt(12'h0FF);
        check("fail1_count", 32'(count), 32'd1);
        attempt(12'h0FF);
        check("fail2_count", 32'(count), 32'd2);
        attempt(12'h5C3);
        check("u1_count",  32'(count), 32'd0);
        check("u1_access", 32'(access), 32'd1);
        check("u1_user",   32'(user_id), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("u1_end_access", 32'(access), 32'd0);
        check("u1_hold_user",  32'(user_id), 32'd1);

        // Three failures -> lockout; a correct password during lockout is ignored
        attempt(12'h0FF);
        attempt(12'h0FF);
        attempt(12'h0FF);
        check("lock_count",  32'(count), 32'd3);
        check("lock_alram",  32'(alram), 32'd1);
        check("lock_locked", 32'(locked), 32'd1);
        passin = 12'h0A8;
        enter  = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            check("lock_hold_locked", 32'(locked), 32'd1);
            check("lock_hold_access", 32'(access), 32'd0);
        end
        enter = 1'b0;
        @(posedge clk);
        #1;
        check("unlock_locked", 32'(locked), 32'd0);
        check("unlock_count",  32'(count), 32'd0);
        check("unlock_alram",  32'(alram), 32'(c_alarm_after));
        check("unlock_access", 32'(access), 32'd0);

        // Disabled all-zero slot never matches
        set_password = {12'h5C3, 12'h000};
        attempt(12'h000);
        check("zslot_count",  32'(count), 32'd1);
        check("zslot_access", 32'(access), 32'd0);

        // Duplicate slots: lowest index wins
        set_password = {12'h0A8, 12'h0A8};
        attempt(12'h0A8);
        check("dup_access", 32'(access), 32'd1);
        check("dup_user",   32'(user_id), 32'd0);
        check("dup_count",  32'(count), 32'd0);

        // Asynchronous reset mid-GRANT
        set_password = {12'h5C3, 12'h0A8};
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rstg_access", 32'(access), 32'd0);
        check("rstg_user",   32'(user_id), 32'd0);
        #1;
        reset = 1'b0;
        attempt(12'h5C3);
        check("post_rstg_access", 32'(access), 32'd1);
        check("post_rstg_user",   32'(user_id), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("post_rstg_end", 32'(access), 32'd0);

        // Asynchronous reset mid-LOCKOUT
        attempt(12'h111);
        attempt(12'h222);
        attempt(12'h333);
        check("lock2_locked", 32'(locked), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rstl_locked", 32'(locked), 32'd0);
        check("rstl_alram",  32'(alram), 32'd0);
        check("rstl_count",  32'(count), 32'd0);
        #1;
        reset = 1'b0;
        attempt(12'h0A8);
        check("post_rstl_access", 32'(access), 32'd1);
        check("post_rstl_user",   32'(user_id), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
